// File: rtl/urt_rx_frame_check.sv
// rtl/urt_rx_frame_check.sv - UART RX frame checker: start/data/parity/stop validation, one outcome per frame.
// Optional saturating error counters are built when FRAME_CHECK_ERR_CNT_EN is defined.
module urt_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK_FRAME_CHECK,
    input  logic                  RST_FRAME_CHECK,
    input  logic                  strt_det_FRAME_CHECK,
    input  logic                  bit_vld_FRAME_CHECK,
    input  logic                  sampled_bit_FRAME_CHECK,
    input  logic                  par_en_FRAME_CHECK,
    input  logic                  par_typ_FRAME_CHECK,
`ifdef FRAME_CHECK_ERR_CNT_EN
    input  logic                  cnt_clr_FRAME_CHECK,
    output logic [CNT_WIDTH-1:0]  glitch_cnt_FRAME_CHECK,
    output logic [CNT_WIDTH-1:0]  par_err_cnt_FRAME_CHECK,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt_FRAME_CHECK,
`endif
    output logic                  busy_FRAME_CHECK,
    output logic [DATA_WIDTH-1:0] data_FRAME_CHECK,
    output logic                  data_vld_FRAME_CHECK,
    output logic                  strt_glitch_FRAME_CHECK,
    output logic                  par_err_FRAME_CHECK,
    output logic                  stp_err_FRAME_CHECK
);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
            $error("DATA_WIDTH must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("STOP_BITS must be 1 or 2");
        end
        if (CNT_WIDTH < 1) begin : g_bad_cnt_width
            $error("CNT_WIDTH must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int BCW = 4;

    state_t                  state;
    state_t                  state_nxt;
    logic [BCW-1:0]          bit_cnt;
    logic                    stop_cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    par_flag;
    logic                    stp_flag;

    logic                    last_data;
    logic                    last_stop;
    logic                    stp_fail;
    logic                    frame_done;
    logic                    glitch_set;
    logic                    good_set;
    logic                    par_set;
    logic                    stp_set;

    assign busy_FRAME_CHECK = (state != S_IDLE);

    // Outcome decode: the stop-flag includes the current (last) stop sample.
    always_comb begin
        last_data  = (bit_cnt == BCW'(DATA_WIDTH - 1));
        last_stop  = (STOP_BITS == 1) || stop_cnt;
        stp_fail   = stp_flag | ~sampled_bit_FRAME_CHECK;
        frame_done = bit_vld_FRAME_CHECK && (state == S_STOP) && last_stop;
        glitch_set = bit_vld_FRAME_CHECK && (state == S_START) && sampled_bit_FRAME_CHECK;
        good_set   = frame_done && !par_flag && !stp_fail;
        par_set    = frame_done && par_flag;
        stp_set    = frame_done && stp_fail;
    end

    always_ff @(posedge CLK_FRAME_CHECK or negedge RST_FRAME_CHECK) begin
        if (!RST_FRAME_CHECK) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (strt_det_FRAME_CHECK) state_nxt = S_START;
            end
            S_START: begin
                if (bit_vld_FRAME_CHECK)
                    state_nxt = sampled_bit_FRAME_CHECK ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_vld_FRAME_CHECK && last_data)
                    state_nxt = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_vld_FRAME_CHECK) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_vld_FRAME_CHECK && last_stop) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_FRAME_CHECK or negedge RST_FRAME_CHECK) begin
        if (!RST_FRAME_CHECK) begin
            bit_cnt                 <= '0;
            stop_cnt                <= 1'b0;
            shreg                   <= '0;
            par_en_q                <= 1'b0;
            par_typ_q               <= 1'b0;
            par_flag                <= 1'b0;
            stp_flag                <= 1'b0;
            data_FRAME_CHECK        <= '0;
            data_vld_FRAME_CHECK    <= 1'b0;
            strt_glitch_FRAME_CHECK <= 1'b0;
            par_err_FRAME_CHECK     <= 1'b0;
            stp_err_FRAME_CHECK     <= 1'b0;
        end else begin
            data_vld_FRAME_CHECK    <= good_set;
            strt_glitch_FRAME_CHECK <= glitch_set;
            par_err_FRAME_CHECK     <= par_set;
            stp_err_FRAME_CHECK     <= stp_set;
            if (good_set) data_FRAME_CHECK <= shreg;

            case (state)
                S_IDLE: begin
                    if (strt_det_FRAME_CHECK) begin
                        par_en_q  <= par_en_FRAME_CHECK;
                        par_typ_q <= par_typ_FRAME_CHECK;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        par_flag  <= 1'b0;
                        stp_flag  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (bit_vld_FRAME_CHECK) begin
                        shreg   <= {sampled_bit_FRAME_CHECK, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                S_PARITY: begin
                    // Mismatch when the sample differs from XOR(data), inverted for odd parity.
                    if (bit_vld_FRAME_CHECK)
                        par_flag <= sampled_bit_FRAME_CHECK ^ (^shreg) ^ par_typ_q;
                end
                S_STOP: begin
                    if (bit_vld_FRAME_CHECK) begin
                        if (!sampled_bit_FRAME_CHECK) stp_flag <= 1'b1;
                        stop_cnt <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FRAME_CHECK_ERR_CNT_EN
    always_ff @(posedge CLK_FRAME_CHECK or negedge RST_FRAME_CHECK) begin
        if (!RST_FRAME_CHECK) begin
            glitch_cnt_FRAME_CHECK  <= '0;
            par_err_cnt_FRAME_CHECK <= '0;
            stp_err_cnt_FRAME_CHECK <= '0;
        end else if (cnt_clr_FRAME_CHECK) begin
            glitch_cnt_FRAME_CHECK  <= '0;
            par_err_cnt_FRAME_CHECK <= '0;
            stp_err_cnt_FRAME_CHECK <= '0;
        end else begin
            if (glitch_set && !(&glitch_cnt_FRAME_CHECK))
                glitch_cnt_FRAME_CHECK <= glitch_cnt_FRAME_CHECK + CNT_WIDTH'(1);
            if (par_set && !(&par_err_cnt_FRAME_CHECK))
                par_err_cnt_FRAME_CHECK <= par_err_cnt_FRAME_CHECK + CNT_WIDTH'(1);
            if (stp_set && !(&stp_err_cnt_FRAME_CHECK))
                stp_err_cnt_FRAME_CHECK <= stp_err_cnt_FRAME_CHECK + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_urt_rx_frame_check.sv
// tb/tb_urt_rx_frame_check.sv - table-driven scoreboard bench for urt_rx_frame_check (1- and 2-stop instances).
module tb_urt_rx_frame_check;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic strt = 1'b0, bv = 1'b0, sb = 1'b0, pe = 1'b0, pt = 1'b0, clr = 1'b0;
    logic sel = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic strt_a, bv_a, strt_b, bv_b;
    assign strt_a = strt & ~sel;
    assign bv_a   = bv & ~sel;
    assign strt_b = strt & sel;
    assign bv_b   = bv & sel;

    logic       a_busy, a_vld, a_gl, a_pe, a_se;
    logic [7:0] a_data;
    logic       b_busy, b_vld, b_gl, b_pe, b_se;
    logic [7:0] b_data;
`ifdef FRAME_CHECK_ERR_CNT_EN
    logic [1:0] a_gcnt, a_pcnt, a_scnt;
    logic [7:0] b_gcnt, b_pcnt, b_scnt;
`endif

    urt_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(2)) u_dut_a (
        .CLK_FRAME_CHECK         (clk),
        .RST_FRAME_CHECK         (rst_n),
        .strt_det_FRAME_CHECK    (strt_a),
        .bit_vld_FRAME_CHECK     (bv_a),
        .sampled_bit_FRAME_CHECK (sb),
        .par_en_FRAME_CHECK      (pe),
        .par_typ_FRAME_CHECK     (pt),
`ifdef FRAME_CHECK_ERR_CNT_EN
        .cnt_clr_FRAME_CHECK     (clr),
        .glitch_cnt_FRAME_CHECK  (a_gcnt),
        .par_err_cnt_FRAME_CHECK (a_pcnt),
        .stp_err_cnt_FRAME_CHECK (a_scnt),
`endif
        .busy_FRAME_CHECK        (a_busy),
        .data_FRAME_CHECK        (a_data),
        .data_vld_FRAME_CHECK    (a_vld),
        .strt_glitch_FRAME_CHECK (a_gl),
        .par_err_FRAME_CHECK     (a_pe),
        .stp_err_FRAME_CHECK     (a_se)
    );

    urt_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(8)) u_dut_b (
        .CLK_FRAME_CHECK         (clk),
        .RST_FRAME_CHECK         (rst_n),
        .strt_det_FRAME_CHECK    (strt_b),
        .bit_vld_FRAME_CHECK     (bv_b),
        .sampled_bit_FRAME_CHECK (sb),
        .par_en_FRAME_CHECK      (pe),
        .par_typ_FRAME_CHECK     (pt),
`ifdef FRAME_CHECK_ERR_CNT_EN
        .cnt_clr_FRAME_CHECK     (clr),
        .glitch_cnt_FRAME_CHECK  (b_gcnt),
        .par_err_cnt_FRAME_CHECK (b_pcnt),
        .stp_err_cnt_FRAME_CHECK (b_scnt),
`endif
        .busy_FRAME_CHECK        (b_busy),
        .data_FRAME_CHECK        (b_data),
        .data_vld_FRAME_CHECK    (b_vld),
        .strt_glitch_FRAME_CHECK (b_gl),
        .par_err_FRAME_CHECK     (b_pe),
        .stp_err_FRAME_CHECK     (b_se)
    );

    logic busy_sel;
    assign busy_sel = sel ? b_busy : a_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       sel;
        logic       glitch;
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic       psample;
        logic [1:0] stops;
        int         bg;
        logic       e_vld;
        logic       e_gl;
        logic       e_pe;
        logic       e_se;
        logic [7:0] e_data;
    } frame_t;

    typedef struct {
        int         cyc;
        logic       vld;
        logic       gl;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } exp_t;

    exp_t   q[$];
    frame_t frames[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input frame_t f);
        exp_t e;
        e.cyc  = 0;
        e.vld  = f.e_vld;
        e.gl   = f.e_gl;
        e.pe   = f.e_pe;
        e.se   = f.e_se;
        e.data = f.e_data;
        return e;
    endfunction

    // Scoreboard: every outcome pulse of the selected instance must match the next queued record.
    always @(negedge clk) begin
        logic       p_sel, p_oth, s_vld, s_gl, s_pe, s_se;
        logic [7:0] s_data;
        exp_t       e;
        s_vld  = sel ? b_vld : a_vld;
        s_gl   = sel ? b_gl  : a_gl;
        s_pe   = sel ? b_pe  : a_pe;
        s_se   = sel ? b_se  : a_se;
        s_data = sel ? b_data : a_data;
        p_sel  = s_vld | s_gl | s_pe | s_se;
        p_oth  = sel ? (a_vld | a_gl | a_pe | a_se) : (b_vld | b_gl | b_pe | b_se);
        if (p_oth) chk("stray_pulse_other_instance", 32'(p_oth), 32'd0);
        if (p_sel) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(p_sel), 32'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("data_vld", 32'(s_vld), 32'(e.vld));
                chk("strt_glitch", 32'(s_gl), 32'(e.gl));
                chk("par_err", 32'(s_pe), 32'(e.pe));
                chk("stp_err", 32'(s_se), 32'(e.se));
                chk("data", 32'(s_data), 32'(e.data));
                chk("busy_at_outcome", 32'(busy_sel), 32'd0);
            end
        end
    end

    task automatic drive_bit(input logic b, input int bg);
        bv = 1'b1;
        sb = b;
        @(posedge clk); #1;
        bv = 1'b0;
        repeat (bg) begin @(posedge clk); #1; end
    endtask

    // Everything after the start bit; the expected record is queued right after the deciding sample.
    task automatic send_body(input frame_t f);
        exp_t e;
        int   nstop;
        e = mk_exp(f);
        nstop = f.sel ? 2 : 1;
        drive_bit(1'b0, f.bg);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) strt = 1'b1;
            drive_bit(f.d[i], f.bg);
            strt = 1'b0;
        end
        if (f.pe) drive_bit(f.psample, f.bg);
        for (int s = 0; s < nstop; s++) begin
            if (s == nstop - 1) begin
                drive_bit(f.stops[s], 0);
                e.cyc = cyc;
                q.push_back(e);
            end else begin
                drive_bit(f.stops[s], f.bg);
            end
        end
    endtask

    task automatic send_frame(input frame_t f);
        exp_t e;
        sel = f.sel;
        pe  = f.pe;
        pt  = f.pt;
        chk("busy_before_start", 32'(busy_sel), 32'd0);
        strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        pe = ~f.pe;
        pt = ~f.pt;
        chk("busy_after_start", 32'(busy_sel), 32'd1);
        if (f.glitch) begin
            e = mk_exp(f);
            drive_bit(1'b1, 0);
            e.cyc = cyc;
            q.push_back(e);
        end else begin
            send_body(f);
        end
        if (f.bg != 0) repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t h;
        //            sel   glitch d      pe    pt    psmp  stops bg  vld   gl    pe    se    data
        frames[0] = '{1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b01, 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A};
        frames[1] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
        frames[2] = '{1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 2'b01, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
        frames[3] = '{1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 2'b01, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03};
        frames[4] = '{1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81};
        frames[5] = '{1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81};
        frames[6] = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 2'b11, 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
        frames[7] = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        frames[8] = '{1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0, 2'b10, 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
        frames[9] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_outputs", 32'({a_busy, a_vld, a_gl, a_pe, a_se, a_data}), 32'd0);
        chk("reset_b_outputs", 32'({b_busy, b_vld, b_gl, b_pe, b_se, b_data}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) send_frame(frames[i]);
        repeat (2) begin @(posedge clk); #1; end

`ifdef FRAME_CHECK_ERR_CNT_EN
        chk("a_glitch_cnt", 32'(a_gcnt), 32'd1);
        chk("a_par_err_cnt", 32'(a_pcnt), 32'd1);
        chk("a_stp_err_cnt", 32'(a_scnt), 32'd1);
        chk("b_par_err_cnt", 32'(b_pcnt), 32'd1);
        chk("b_stp_err_cnt", 32'(b_scnt), 32'd2);
`endif

        // strt_det and bit_vld together in IDLE: only the start is taken
        sel = 1'b0; pe = 1'b0; pt = 1'b0;
        strt = 1'b1; bv = 1'b1; sb = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0; bv = 1'b0;
        chk("busy_after_strt_with_bitvld", 32'(a_busy), 32'd1);
        h = '{1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h96};
        send_body(h);
        repeat (3) begin @(posedge clk); #1; end

        // asynchronous reset in the middle of a data phase
        sel = 1'b0; pe = 1'b0;
        strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        drive_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 0);
        chk("busy_mid_frame", 32'(a_busy), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("busy_in_reset", 32'(a_busy), 32'd0);
        chk("data_in_reset", 32'(a_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_reset", 32'(a_busy), 32'd0);
`ifdef FRAME_CHECK_ERR_CNT_EN
        chk("a_glitch_cnt_after_reset", 32'(a_gcnt), 32'd0);
`endif
        h = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        send_frame(h);

`ifdef FRAME_CHECK_ERR_CNT_EN
        h = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        for (int i = 0; i < 5; i++) send_frame(h);
        chk("a_glitch_cnt_saturated", 32'(a_gcnt), 32'd3);
        clr = 1'b1;
        send_frame(h);
        clr = 1'b0;
        chk("a_glitch_cnt_clr_priority", 32'(a_gcnt), 32'd0);
`endif

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/urt_rx_frame_check.md
# urt_rx_frame_check

Parametrised UART receive frame checker: the successor to the single-bit start-glitch check. It runs a per-frame state machine over the mid-bit samples from the RX sampler, checking start, data, optional parity and 1 or 2 stop bits. Each frame ends in exactly one outcome: a data-valid pulse or an error report. It sits between the RX edge/bit sampler and the RX output register / bus interface.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- CNT_WIDTH, 8, width of each error counter; only used with the counter feature.
- CLK_FRAME_CHECK  input  1  single clock; all logic is rising-edge.
- RST_FRAME_CHECK  input  1  asynchronous, active-low reset.
- strt_det_FRAME_CHECK  input  1  one-cycle pulse: falling edge seen on the RX line.
- bit_vld_FRAME_CHECK  input  1  one-cycle pulse: sampled_bit is the mid-bit value.
- sampled_bit_FRAME_CHECK  input  1  majority-voted bit sample.
- par_en_FRAME_CHECK  input  1  parity bit present.
- par_typ_FRAME_CHECK  input  1  0 = even parity, 1 = odd parity.
- cnt_clr_FRAME_CHECK  input  1  synchronous clear of the error counters (feature only).
- busy_FRAME_CHECK  output  1  high in any state other than IDLE.
- data_FRAME_CHECK  output  DATA_WIDTH  last good frame, LSB = first received bit.
- data_vld_FRAME_CHECK  output  1  one-cycle pulse: good frame.
- strt_glitch_FRAME_CHECK  output  1  one-cycle pulse: false start.
- par_err_FRAME_CHECK  output  1  one-cycle pulse at frame end.
- stp_err_FRAME_CHECK  output  1  one-cycle pulse at frame end.
- glitch_cnt / par_err_cnt / stp_err_cnt _FRAME_CHECK  output  CNT_WIDTH each  saturating error counters (feature only).

## Operation
- States:
  - IDLE -> START on strt_det.
  - START, on bit_vld: sample 0 -> DATA; sample 1 -> strt_glitch pulse, -> IDLE.
  - DATA: shift each bit in at the MSB, shifting right. After DATA_WIDTH bits -> PARITY if the latched par_en is set, else STOP.
  - PARITY: compare the sample against the expected parity (XOR of the data bits; inverted for odd). Record any mismatch in an internal flag, -> STOP.
  - STOP: each of the STOP_BITS samples must be 1; any 0 sets an internal flag. After the last stop bit, report the frame outcome and go to IDLE.
- par_en and par_typ are latched on the IDLE -> START transition and held for the whole frame.
- Frame outcome:
  - If neither flag is set: load data, pulse data_vld.
  - Otherwise: pulse par_err and/or stp_err (both may pulse together). data and data_vld are untouched.
- strt_det outside IDLE is ignored. bit_vld in IDLE is ignored.
- strt_det and bit_vld high in the same cycle while in IDLE: take the IDLE -> START transition only; the bit_vld is not consumed.
- Reset values: all outputs 0, data = 0, state IDLE, flags and counters 0.
- Reset asserted mid-frame: immediate return to IDLE; no outcome pulse for the aborted frame.

## Timing
- Every outcome pulse is registered and high for exactly one cycle. It appears the cycle after the bit_vld that decided it, i.e. after the START sample or after the last stop-bit sample.
- data is stable from the data_vld cycle until the next good frame.
- busy:
  - rises the cycle after strt_det;
  - falls in the same cycle the outcome pulse rises.
- A new strt_det is accepted in the cycle the outcome pulse is high, since the state is already IDLE.
- Back-to-back bit_vld on consecutive cycles must be handled; there is no minimum spacing.

## Configuration
- Macro: FRAME_CHECK_ERR_CNT_EN.
- Defined:
  - Three CNT_WIDTH counters count strt_glitch, par_err and stp_err pulses, each incrementing in the same cycle as its pulse.
  - Counters saturate at all-ones.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Undefined: cnt_clr and the three counter ports do not exist, and no counter logic is built.

## Test plan
- Good frame: DATA_WIDTH=8, no parity, 1 stop, bits 0,0x5A LSB-first,1 -> data=0x5A, data_vld one cycle, no error pulses.
- Start glitch: strt_det then first bit_vld with sample 1 -> strt_glitch one cycle after that bit_vld; state back to IDLE; glitch_cnt=1 (macro on).
- Parity: par_en=1, odd, data 0x03 with a parity sample of 0 -> par_err pulse, no data_vld, data keeps the previous value. Repeat with parity sample 1 -> data_vld.
- Stop error with 2 stop bits: stop samples 1,0 -> stp_err. With a bad parity bit in the same frame as well -> par_err and stp_err pulse in the same cycle.
- Reset mid-frame: assert RST after 4 data bits -> busy=0 immediately, no pulses. The next full frame 0xA5 is received correctly.
- Counter saturation (macro on, CNT_WIDTH=2): 5 glitches -> glitch_cnt=3. Then cnt_clr together with a 6th glitch -> glitch_cnt=0.
